// File: rtl/flow_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module      : flow_pipeline_if
// Description : Operand/result bundle for the two-stage dot-product unit.
//               The master drives the four operands and samples C; the
//               slave (the pipeline) consumes the operands and drives C.
// Revision    : 1.0 - initial release
// ============================================================================
interface flow_pipeline_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] B1;
   logic [WIDTH-1:0] A2;
   logic [WIDTH-1:0] B2;
   logic [WIDTH-1:0] C;

   // Operand source / result consumer side
   modport master (
      output A1,
      output B1,
      output A2,
      output B2,
      input  C
   );

   // Pipeline side
   modport slave (
      input  A1,
      input  B1,
      input  A2,
      input  B2,
      output C
   );
endinterface
`default_nettype wire

// File: rtl/flow_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : flow_pipeline
// Description : Two-stage pipelined dot product C = A1*B1 + A2*B2, all
//               arithmetic unsigned and truncated to WIDTH bits. Stage 1
//               registers both products, stage 2 registers their sum, so a
//               result appears two rising edges after its operands are
//               sampled. One new operand set is accepted every cycle; there
//               is no stall or valid tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module flow_pipeline #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   flow_pipeline_if.slave       bus
);

   // Stage 1 product registers and their next-state values
   logic [WIDTH-1:0] p1_q;
   logic [WIDTH-1:0] p2_q;
   logic [WIDTH-1:0] p1_d;
   logic [WIDTH-1:0] p2_d;

   // Stage 2 result register and its next-state value
   logic [WIDTH-1:0] c_q;
   logic [WIDTH-1:0] c_d;

   // Stage 1: single-cycle combinational multipliers; the assignment context
   // is WIDTH bits, so the upper product bits are dropped here.
   always_comb begin
      p1_d = bus.A1 * bus.B1;
      p2_d = bus.A2 * bus.B2;
   end

   // Stage 2: sum of the registered products, carry out discarded.
   always_comb begin
      c_d = p1_q + p2_q;
   end

   // Both stages advance together; reset clears every stage so a flush
   // mid-stream leaves no stale products behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_q <= '0;
         p2_q <= '0;
         c_q  <= '0;
      end else begin
         p1_q <= p1_d;
         p2_q <= p2_d;
         c_q  <= c_d;
      end
   end

   // The result leaves straight from the stage 2 register.
   assign bus.C = c_q;

endmodule
`default_nettype wire

// File: tb/tb_flow_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_pipeline
// Description : Self-checking bench for flow_pipeline. A reference model
//               remembers the operands and reset level of the previous edge
//               and derives the expected C from the arithmetic definition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_pipeline;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   flow_pipeline_if #(.WIDTH(WIDTH)) bus ();

   flow_pipeline #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state: what the DUT saw on the previous rising edge
   logic [WIDTH-1:0] prev_a1 = '0;
   logic [WIDTH-1:0] prev_b1 = '0;
   logic [WIDTH-1:0] prev_a2 = '0;
   logic [WIDTH-1:0] prev_b2 = '0;
   bit               prev_rst_n = 1'b0;

   function automatic logic [WIDTH-1:0] dot(input logic [WIDTH-1:0] a1, b1, a2, b2);
      logic [63:0] full;
      full = 64'(a1) * 64'(b1) + 64'(a2) * 64'(b2);
      return full[WIDTH-1:0];
   endfunction

   task automatic compare(input string tag, input logic [WIDTH-1:0] expected);
      checks++;
      assert (bus.C === expected) else begin
         errors++;
         $error("FAIL %s: C=%h expected %h", tag, bus.C, expected);
      end
   endtask

   // Apply one operand set across one rising edge, then check C against the
   // model: 0 if reset was low on this edge or the previous one, otherwise
   // the dot product of the operands sampled one edge earlier.
   task automatic step(input logic [WIDTH-1:0] a1, b1, a2, b2,
                       input bit rn, input string tag);
      logic [WIDTH-1:0] exp_c;
      bus.A1 = a1;
      bus.B1 = b1;
      bus.A2 = a2;
      bus.B2 = b2;
      rst_n  = rn;
      @(posedge clk);
      #1;
      exp_c = (!rn || !prev_rst_n) ? '0 : dot(prev_a1, prev_b1, prev_a2, prev_b2);
      prev_a1 = a1;
      prev_b1 = b1;
      prev_a2 = a2;
      prev_b2 = b2;
      prev_rst_n = rn;
      compare(tag, exp_c);
   endtask

   function automatic logic [WIDTH-1:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      bus.A1 = '0;
      bus.B1 = '0;
      bus.A2 = '0;
      bus.B2 = '0;

      // Reset held for 3 edges with operands at 7
      for (int i = 0; i < 3; i++) begin
         step(7, 7, 7, 7, 1'b0, "reset_hold");
         compare("reset_hold_zero", '0);
      end
      step(7, 7, 7, 7, 1'b1, "reset_release1");
      compare("reset_release1_zero", '0);
      step(7, 7, 7, 7, 1'b1, "reset_release2");
      compare("reset_release2_98", 32'd98);

      // Latency and streaming
      step(0, 1, 2, 3, 1'b1, "stream_a");
      step(1, 2, 1, 0, 1'b1, "stream_b");
      compare("latency_6", 32'd6);
      step(5, 5, 5, 5, 1'b1, "stream_c");
      compare("stream_2", 32'd2);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1, "ovf_a");
      compare("stream_50", 32'd50);

      // Wrap-around cases
      step(32'h0001_0000, 32'h0001_0000, 3, 4, 1'b1, "ovf_b");
      compare("ovf_sum_wrap", 32'h0000_0000);
      step(32'hFFFF_FFFF, 2, 0, 0, 1'b1, "ovf_c");
      compare("ovf_prod_wrap_12", 32'd12);
      step(32'h8000_0000, 2, 32'h8000_0000, 2, 1'b1, "ovf_d");
      compare("ovf_fffffffe", 32'hFFFF_FFFE);
      step(1, 1, 1, 1, 1'b1, "ovf_e");
      compare("ovf_both_wrap", 32'h0000_0000);

      // Mid-stream reset with (1,1,1,1) streaming
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1'b1, "mid_pre");
      compare("mid_steady_2", 32'd2);
      step(1, 1, 1, 1, 1'b0, "mid_rst");
      compare("mid_rst_zero", '0);
      step(1, 1, 1, 1, 1'b1, "mid_post1");
      compare("mid_post1_zero", '0);
      step(1, 1, 1, 1, 1'b1, "mid_post2");
      compare("mid_post2_2", 32'd2);

      // Hold stability, including mid-cycle samples
      for (int i = 0; i < 10; i++) begin
         step(3, 4, 5, 6, 1'b1, "hold");
         if (i >= 1) begin
            compare("hold_42", 32'd42);
            @(negedge clk);
            compare("hold_42_mid", 32'd42);
         end
      end

      // Randomized stream with occasional reset pulses
      for (int i = 0; i < 300; i++) begin
         step(rand_op(), rand_op(), rand_op(), rand_op(),
              ($urandom_range(0, 15) != 0), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
